// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz raster timing constants shared by the sync generator and the
// pixel-colouring stage.
package vga_timing_pkg;

    localparam int COUNT_W       = 10;

    localparam int VGA_DIV       = 4;
    localparam int VGA_H_TOTAL   = 800;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_VIS_START = 144;
    localparam int VGA_H_VIS_END = 783;
    localparam int VGA_V_TOTAL   = 525;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_VIS_START = 35;
    localparam int VGA_V_VIS_END = 514;

    // Inclusive unsigned range test used for the visible-window decode.
    function automatic logic in_range(
        input logic [COUNT_W-1:0] val,
        input logic [COUNT_W-1:0] lo,
        input logic [COUNT_W-1:0] hi
    );
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster outputs of the sync generator: counters, sync pulses and strobes.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic [COUNT_W-1:0] hCount;
    logic [COUNT_W-1:0] vCount;
    logic               bright;
    logic               hSync;
    logic               vSync;
    logic               pix_en;
    logic               frame_tick;

    modport master (
        output hCount, vCount, bright, hSync, vSync, pix_en, frame_tick
    );

    modport slave (
        input hCount, vCount, bright, hSync, vSync, pix_en, frame_tick
    );

endinterface

// File: rtl/vga_sync_gen_pix_div.sv
// Reusable clock-enable divider: pix_en is a registered one-clk pulse on the
// last system clock of every DIV-clock pixel period.
module pix_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en
);

    localparam int W = $clog2(DIV);

    logic [W-1:0] div_cnt_r;
    logic [W-1:0] div_next_s;
    logic         pix_en_r;

    // Next divider count, wrapping at DIV-1.
    always_comb begin
        div_next_s = div_cnt_r;
        if (div_cnt_r == W'(DIV - 1)) begin
            div_next_s = '0;
        end else begin
            div_next_s = div_cnt_r + W'(1);
        end
    end

    // Divider register; the pulse is decoded from the next count so it lines up with DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= '0;
            pix_en_r  <= 1'b0;
        end else begin
            div_cnt_r <= div_next_s;
            pix_en_r  <= (div_next_s == W'(DIV - 1));
        end
    end

    assign pix_en = pix_en_r;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel enable, h/v counters and registered
// sync/visible decode aligned with the counters.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int DIV         = VGA_DIV,
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_VIS_START = VGA_H_VIS_START,
    parameter int H_VIS_END   = VGA_H_VIS_END,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_VIS_START = VGA_V_VIS_START,
    parameter int V_VIS_END   = VGA_V_VIS_END
) (
    input  logic                  clk,
    input  logic                  rst,
    vga_sync_gen_if.master        sync
);

    logic               pix_en_s;
    logic [COUNT_W-1:0] h_cnt_r;
    logic [COUNT_W-1:0] v_cnt_r;
    logic [COUNT_W-1:0] h_next_s;
    logic [COUNT_W-1:0] v_next_s;
    logic               frame_wrap_s;
    logic               hsync_next_s;
    logic               vsync_next_s;
    logic               bright_next_s;
    logic               hsync_r;
    logic               vsync_r;
    logic               bright_r;
    logic               frame_tick_r;

    pix_div #(.DIV(DIV)) u_pix_div (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en_s)
    );

    // Next-state counters; they only move on the edge that ends a pixel.
    always_comb begin
        h_next_s     = h_cnt_r;
        v_next_s     = v_cnt_r;
        frame_wrap_s = 1'b0;
        if (pix_en_s) begin
            if (h_cnt_r == COUNT_W'(H_TOTAL - 1)) begin
                h_next_s = '0;
                if (v_cnt_r == COUNT_W'(V_TOTAL - 1)) begin
                    v_next_s     = '0;
                    frame_wrap_s = 1'b1;
                end else begin
                    v_next_s = v_cnt_r + COUNT_W'(1);
                end
            end else begin
                h_next_s = h_cnt_r + COUNT_W'(1);
            end
        end else begin
            h_next_s = h_cnt_r;
        end
    end

    // Decode from next-state counts so the registered flags never lag the counters.
    always_comb begin
        hsync_next_s  = (h_next_s >= COUNT_W'(H_SYNC));
        vsync_next_s  = (v_next_s >= COUNT_W'(V_SYNC));
        bright_next_s = in_range(h_next_s, COUNT_W'(H_VIS_START), COUNT_W'(H_VIS_END)) &&
                        in_range(v_next_s, COUNT_W'(V_VIS_START), COUNT_W'(V_VIS_END));
    end

    // Counter and output registers; reset abandons the current line and frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_r      <= '0;
            v_cnt_r      <= '0;
            hsync_r      <= 1'b0;
            vsync_r      <= 1'b0;
            bright_r     <= 1'b0;
            frame_tick_r <= 1'b0;
        end else begin
            h_cnt_r      <= h_next_s;
            v_cnt_r      <= v_next_s;
            hsync_r      <= hsync_next_s;
            vsync_r      <= vsync_next_s;
            bright_r     <= bright_next_s;
            frame_tick_r <= frame_wrap_s;
        end
    end

    assign sync.hCount     = h_cnt_r;
    assign sync.vCount     = v_cnt_r;
    assign sync.hSync      = hsync_r;
    assign sync.vSync      = vsync_r;
    assign sync.bright     = bright_r;
    assign sync.pix_en     = pix_en_s;
    assign sync.frame_tick = frame_tick_r;

endmodule
